// File: rtl/pulse_sync_pkg.sv
// Shared defaults for the slow-to-fast pulse synchronizer.
// Holds synchronizer depth, drop-counter width and the drop-counter saturation pattern.
package pulse_sync_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 8;

    // All-ones saturation pattern; each counter uses its low CNT_W bits (CNT_W <= 32).
    localparam logic [31:0] DROP_CNT_SAT = 32'hFFFF_FFFF;

endpackage : pulse_sync_pkg

// File: rtl/sync_ff.sv
// Multi-flop synchronizer chain with asynchronous active-low clear.
// q_o is the last stage; depth is set by STAGES (legal >= 2).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // NOTE: every stage is cleared by reset so a half-finished toggle cannot survive it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : sync_ff

// File: rtl/pulse_sync_s2f.sv
// Toggle-based pulse synchronizer, clk_slow -> clk_fast, with request/ack handshake.
// Define PULSE_SYNC_DROP_CNT_EN to build the saturating drop counter; otherwise drop_cnt is 0.
module pulse_sync_s2f
    import pulse_sync_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk_fast,
    input  logic             clk_slow,
    input  logic             rst_n,
    input  logic             pulse_in,
    output logic             busy,
    output logic             pulse_out,
    output logic [CNT_W-1:0] drop_cnt
);

    logic req_tgl_q, req_tgl_d;
    logic ack_sync;
    logic accept;
    logic req_sync;
    logic req_prev_q;
    logic pulse_out_q, pulse_out_d;

    // Slow domain: a transfer is in flight until the ack toggle matches the request toggle.
    assign busy = req_tgl_q ^ ack_sync;

    always_comb begin
        accept    = pulse_in & ~busy;
        req_tgl_d = req_tgl_q ^ accept;
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            req_tgl_q <= 1'b0;
        end else begin
            req_tgl_q <= req_tgl_d;
        end
    end

    sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk_fast),
        .rst_n (rst_n),
        .d_i   (req_tgl_q),
        .q_o   (req_sync)
    );

    // Fast domain: edge-detect the synchronized toggle; req_prev doubles as the ack toggle.
    always_comb begin
        pulse_out_d = req_sync ^ req_prev_q;
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            req_prev_q  <= 1'b0;
            pulse_out_q <= 1'b0;
        end else begin
            req_prev_q  <= req_sync;
            pulse_out_q <= pulse_out_d;
        end
    end

    assign pulse_out = pulse_out_q;

    sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk_slow),
        .rst_n (rst_n),
        .d_i   (req_prev_q),
        .q_o   (ack_sync)
    );

`ifdef PULSE_SYNC_DROP_CNT_EN
    localparam logic [CNT_W-1:0] CNT_SAT = DROP_CNT_SAT[CNT_W-1:0];

    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (pulse_in && busy && (drop_cnt_q != CNT_SAT)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule : pulse_sync_s2f

// File: tb/tb_pulse_sync_s2f.sv
// Directed self-checking bench for pulse_sync_s2f (10 MHz -> 100 MHz, then 50 MHz -> 50 MHz).
// Drop-count expectations follow whether PULSE_SYNC_DROP_CNT_EN is defined for the build.
`timescale 1ns/1ps
module tb_pulse_sync_s2f;

`ifdef PULSE_SYNC_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk_fast;
    logic       clk_slow;
    logic       rst_n;
    logic       pulse_in;
    logic       busy;
    logic       pulse_out;
    logic [7:0] drop_cnt;

    real slow_half = 50.0;
    real fast_half = 5.0;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int dup_cnt = 0;
    bit prev_po = 1'b0;
    int base;

    pulse_sync_s2f #(.SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk_fast  (clk_fast),
        .clk_slow  (clk_slow),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in),
        .busy      (busy),
        .pulse_out (pulse_out),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        clk_slow = 1'b0;
        forever #(slow_half) clk_slow = ~clk_slow;
    end

    initial begin
        clk_fast = 1'b0;
        #1;
        forever #(fast_half) clk_fast = ~clk_fast;
    end

    // Count output pulses and flag any pulse wider than one clk_fast cycle.
    always @(negedge clk_fast) begin
        if (pulse_out === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            if (prev_po) dup_cnt = dup_cnt + 1;
        end
        prev_po = (pulse_out === 1'b1);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_drop(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    initial begin
        rst_n    = 1'b0;
        pulse_in = 1'b0;
        #20;
        check("rst_pulse_out", {31'd0, pulse_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        @(negedge clk_fast);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_slow);
        #1;

        // Single one-cycle request: latency, pulse width, busy duration.
        base = pulse_cnt;
        pulse_in = 1'b1;
        @(posedge clk_slow);
        #1;
        pulse_in = 1'b0;
        check("t1_busy_s0", {31'd0, busy}, 32'd1);
        repeat (2) @(posedge clk_fast);
        #1;
        check("t1_po_edge2", {31'd0, pulse_out}, 32'd0);
        @(posedge clk_fast);
        #1;
        check("t1_po_edge3", {31'd0, pulse_out}, 32'd1);
        @(posedge clk_fast);
        #1;
        check("t1_po_edge4", {31'd0, pulse_out}, 32'd0);
        @(posedge clk_slow);
        #1;
        check("t1_busy_s1", {31'd0, busy}, 32'd1);
        @(posedge clk_slow);
        #1;
        check("t1_busy_s2", {31'd0, busy}, 32'd0);
        check("t1_pulses", 32'(pulse_cnt - base), 32'd1);
        check("t1_drop_cnt", {24'd0, drop_cnt}, 32'd0);

        // pulse_in held four slow cycles: cycles 0 and 3 accepted, 1 and 2 dropped.
        repeat (2) @(posedge clk_slow);
        #1;
        base = pulse_cnt;
        pulse_in = 1'b1;
        repeat (4) @(posedge clk_slow);
        #1;
        pulse_in = 1'b0;
        repeat (6) @(posedge clk_slow);
        #1;
        check("t2_pulses", 32'(pulse_cnt - base), 32'd2);
        check("t2_drop_cnt", {24'd0, drop_cnt}, exp_drop(2));
        check("t2_busy_idle", {31'd0, busy}, 32'd0);

        // Reset clears the counter.
        rst_n = 1'b0;
        #5;
        check("t2r_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        check("t2r_busy", {31'd0, busy}, 32'd0);
        @(negedge clk_fast);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_slow);
        #1;

        // Held 400 slow cycles: accepted every third cycle (134), 266 drops saturate at 255.
        base = pulse_cnt;
        pulse_in = 1'b1;
        repeat (400) @(posedge clk_slow);
        #1;
        pulse_in = 1'b0;
        repeat (6) @(posedge clk_slow);
        #1;
        check("t3_pulses", 32'(pulse_cnt - base), 32'd134);
        check("t3_drop_sat", {24'd0, drop_cnt}, exp_drop(255));
        base = pulse_cnt;
        pulse_in = 1'b1;
        repeat (10) @(posedge clk_slow);
        #1;
        pulse_in = 1'b0;
        repeat (6) @(posedge clk_slow);
        #1;
        check("t3_pulses_more", 32'(pulse_cnt - base), 32'd4);
        check("t3_drop_hold", {24'd0, drop_cnt}, exp_drop(255));

        // Reset one fast cycle after the request toggles: transfer is discarded.
        base = pulse_cnt;
        pulse_in = 1'b1;
        @(posedge clk_slow);
        #1;
        pulse_in = 1'b0;
        @(posedge clk_fast);
        #1;
        rst_n = 1'b0;
        #1;
        check("t4_busy_in_rst", {31'd0, busy}, 32'd0);
        #30;
        @(negedge clk_fast);
        rst_n = 1'b1;
        repeat (5) @(posedge clk_slow);
        #1;
        check("t4_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        pulse_in = 1'b1;
        @(posedge clk_slow);
        #1;
        pulse_in = 1'b0;
        repeat (5) @(posedge clk_slow);
        #1;
        check("t4_next_pulse", 32'(pulse_cnt - base), 32'd1);
        check("t4_busy_after", {31'd0, busy}, 32'd0);

        // Both clocks 50 MHz: 100 one-cycle requests, one every 8 slow cycles.
        slow_half = 10.0;
        fast_half = 10.0;
        repeat (4) @(posedge clk_slow);
        #1;
        base = pulse_cnt;
        for (int i = 0; i < 100; i++) begin
            pulse_in = 1'b1;
            @(posedge clk_slow);
            #1;
            pulse_in = 1'b0;
            repeat (7) @(posedge clk_slow);
            #1;
        end
        repeat (20) @(posedge clk_slow);
        #1;
        check("t5_pulses", 32'(pulse_cnt - base), 32'd100);
        check("t5_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("wide_pulses", 32'(dup_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pulse_sync_s2f
